mem_bus_ctrl: RTL and testbench

//   Bus controller between the core (pc_instr fetch port and data port) and the external 8-bit

---
 rtl/mem_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Bus controller that multiplexes the core's fetch and data ports onto a shared 8-bit
// bidirectional memory bus, with read turnaround, ready handshake and a data-phase timeout.
module mem_bus_ctrl #(
   parameter int TURN_CYCLES = 1,
   parameter int TIMEOUT     = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fetch_req,
   input  logic [7:0] fetch_addr,
   output logic       fetch_ack,
   output logic [7:0] fetch_data,
   input  logic       dmem_req,
   input  logic       dmem_we,
   input  logic [7:0] dmem_addr,
   input  logic [7:0] dmem_wdata,
   output logic       dmem_ack,
   output logic [7:0] dmem_rdata,
   output logic       err,
   output logic       rw_mem,
   output logic [7:0] mem_out,
   input  logic [7:0] mem_in,
   output logic       mem_ale,
   output logic       mem_we,
   input  logic       mem_rdy,
   output logic       busy
);

   localparam int WW = $clog2(TIMEOUT + 1);
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [WW-1:0] WaitLast = WW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TurnLast = TW'(TURN_CYCLES - 1);

   typedef enum logic [2:0] {
      Idle,
      Addr,
      Turn,
      RData,
      WData,
      Done
   } state_t;

   state_t        state_q, state_d;
   logic          gntFetch_q, gntFetch_d;
   logic [1:0]    starve_q, starve_d;
   logic          we_q, we_d;
   logic [7:0]    addr_q, addr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [TW-1:0] turn_q, turn_d;
   logic          timedOut_q, timedOut_d;
   logic [7:0]    fetchData_q, fetchData_d;
   logic [7:0]    dmemRdata_q, dmemRdata_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= Idle;
         gntFetch_q  <= 1'b0;
         starve_q    <= 2'd0;
         we_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         wait_q      <= '0;
         turn_q      <= '0;
         timedOut_q  <= 1'b0;
         fetchData_q <= 8'h00;
         dmemRdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         gntFetch_q  <= gntFetch_d;
         starve_q    <= starve_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wait_q      <= wait_d;
         turn_q      <= turn_d;
         timedOut_q  <= timedOut_d;
         fetchData_q <= fetchData_d;
         dmemRdata_q <= dmemRdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gntFetch_d  = gntFetch_q;
      starve_d    = starve_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wait_d      = wait_q;
      turn_d      = turn_q;
      timedOut_d  = timedOut_q;
      fetchData_d = fetchData_q;
      dmemRdata_d = dmemRdata_q;

      unique case (state_q)
         Idle: begin
            wait_d     = '0;
            turn_d     = '0;
            timedOut_d = 1'b0;
            // Data port has priority unless fetch has already lost two grants in a row
            if (fetch_req && (!dmem_req || starve_q == 2'd2)) begin
               gntFetch_d = 1'b1;
               we_d       = 1'b0;
               addr_d     = fetch_addr;
               starve_d   = 2'd0;
               state_d    = Addr;
            end else if (dmem_req) begin
               gntFetch_d = 1'b0;
               we_d       = dmem_we;
               addr_d     = dmem_addr;
               wdata_d    = dmem_wdata;
               starve_d   = fetch_req ? starve_q + 2'd1 : 2'd0;
               state_d    = Addr;
            end
         end
         Addr: begin
            state_d = we_q ? WData : Turn;
         end
         Turn: begin
            if (turn_q == TurnLast) begin
               turn_d  = '0;
               state_d = RData;
            end else begin
               turn_d = turn_q + 1'b1;
            end
         end
         RData: begin
            if (mem_rdy || wait_q == WaitLast) begin
               timedOut_d = !mem_rdy;
               if (gntFetch_q) fetchData_d = mem_rdy ? mem_in : 8'hFF;
               else            dmemRdata_d = mem_rdy ? mem_in : 8'hFF;
               state_d = Done;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         WData: begin
            if (mem_rdy || wait_q == WaitLast) begin
               timedOut_d = !mem_rdy;
               state_d    = Done;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         Done: begin
            state_d = Idle;
         end
         default: begin
            state_d = Idle;
         end
      endcase
   end

   // The bus is only driven in the address and write-data phases
   assign busy       = (state_q != Idle);
   assign rw_mem     = (state_q == Addr) || (state_q == WData);
   assign mem_ale    = (state_q == Addr);
   assign mem_we     = (state_q == WData);
   assign mem_out    = (state_q == Addr)  ? addr_q :
                       (state_q == WData) ? wdata_q : 8'h00;
   assign fetch_ack  = (state_q == Done) && gntFetch_q;
   assign dmem_ack   = (state_q == Done) && !gntFetch_q;
   assign err        = (state_q == Done) && timedOut_q;
   assign fetch_data = fetchData_q;
   assign dmem_rdata = dmemRdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: stimulus pushes expected acks, a negedge monitor checks them,
// plus a second instance with a three-cycle read turnaround.
module tb_mem_bus_ctrl;

   typedef struct {
      bit         isFetch;
      bit         err;
      int         ackCyc;
      logic [7:0] addr;
      int         weCycles;
      logic [7:0] wdata;
      logic [7:0] fdata;
      logic [7:0] ddata;
   } expT;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         cyc = 0;
   int         nChecks = 0;
   int         nFail = 0;

   logic       fetchReq = 0, dmemReq = 0, dmemWe = 0;
   logic [7:0] fetchAddr = 0, dmemAddr = 0, dmemWdata = 0;
   logic       fetchAck, dmemAck, err, rwMem, memAle, memWe, busy, memRdy;
   logic [7:0] fetchData, dmemRdata, memOut, memIn;

   logic       fetchReqB = 0, dmemReqB = 0, dmemWeB = 0;
   logic [7:0] fetchAddrB = 0, dmemAddrB = 0, dmemWdataB = 0;
   logic       fetchAckB, dmemAckB, errB, rwMemB, memAleB, memWeB, busyB;
   logic       memRdyB = 1'b1;
   logic [7:0] fetchDataB, dmemRdataB, memOutB, memInB;

   logic [7:0] tbMem [256];
   logic [7:0] aleAddrA = 0, aleAddrB = 0;
   int         rdyFrom = 0;
   bit         rdyStuck = 0;

   expT        expQ[$];
   expT        e;
   int         aleCnt = 0, weCnt = 0, ackSeen = 0;
   logic [7:0] aleSeen = 0, weSeen = 0;
   bit         weChanged = 0;
   logic [7:0] trkFetch = 0, trkDmem = 0;

   mem_bus_ctrl #(.TURN_CYCLES(1), .TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetchReq), .fetch_addr(fetchAddr), .fetch_ack(fetchAck), .fetch_data(fetchData),
      .dmem_req(dmemReq), .dmem_we(dmemWe), .dmem_addr(dmemAddr), .dmem_wdata(dmemWdata),
      .dmem_ack(dmemAck), .dmem_rdata(dmemRdata), .err(err),
      .rw_mem(rwMem), .mem_out(memOut), .mem_in(memIn), .mem_ale(memAle), .mem_we(memWe),
      .mem_rdy(memRdy), .busy(busy)
   );

   mem_bus_ctrl #(.TURN_CYCLES(3), .TIMEOUT(15)) dutB (
      .clk(clk), .rst(rst),
      .fetch_req(fetchReqB), .fetch_addr(fetchAddrB), .fetch_ack(fetchAckB), .fetch_data(fetchDataB),
      .dmem_req(dmemReqB), .dmem_we(dmemWeB), .dmem_addr(dmemAddrB), .dmem_wdata(dmemWdataB),
      .dmem_ack(dmemAckB), .dmem_rdata(dmemRdataB), .err(errB),
      .rw_mem(rwMemB), .mem_out(memOutB), .mem_in(memInB), .mem_ale(memAleB), .mem_we(memWeB),
      .mem_rdy(memRdyB), .busy(busyB)
   );

   // Memory model: latch the address seen under ALE and return the stored byte
   assign memIn  = tbMem[aleAddrA];
   assign memInB = tbMem[aleAddrB];
   assign memRdy = !rdyStuck && (cyc >= rdyFrom);

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (memAle) aleAddrA = memOut;
      if (memAleB) aleAddrB = memOutB;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: accumulate bus activity per transaction and score it when an ack appears
   always @(negedge clk) begin
      if (rst) begin
         aleCnt = 0;
         weCnt = 0;
         weChanged = 0;
      end else begin
         if (memAle || memWe) checkOutput("bus driven under strobe", 32'(rwMem), 1);
         if (memAle) begin
            aleCnt++;
            aleSeen = memOut;
         end
         if (memWe) begin
            if (weCnt > 0 && memOut !== weSeen) weChanged = 1;
            weSeen = memOut;
            weCnt++;
         end
         if (fetchAck || dmemAck) begin
            ackSeen++;
            checkOutput("scoreboard entry present", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
               e = expQ.pop_front();
               checkOutput("ack port", 32'(fetchAck), 32'(e.isFetch));
               checkOutput("single ack", 32'(fetchAck & dmemAck), 0);
               checkOutput("fetch_data", 32'(fetchData), 32'(e.fdata));
               checkOutput("dmem_rdata", 32'(dmemRdata), 32'(e.ddata));
               checkOutput("err", 32'(err), 32'(e.err));
               checkOutput("ack cycle", 32'(cyc), 32'(e.ackCyc));
               checkOutput("ale cycles", 32'(aleCnt), 1);
               checkOutput("ale address", 32'(aleSeen), 32'(e.addr));
               checkOutput("we cycles", 32'(weCnt), 32'(e.weCycles));
               if (e.weCycles > 0) begin
                  checkOutput("write data on bus", 32'(weSeen), 32'(e.wdata));
                  checkOutput("write data stable", 32'(weChanged), 0);
               end
            end
            aleCnt = 0;
            weCnt = 0;
            weChanged = 0;
         end else begin
            checkOutput("err only with ack", 32'(err), 0);
         end
      end
   end

   task automatic waitAcks(input int target, input int budget);
      for (int i = 0; i < budget && ackSeen < target; i++) @(posedge clk);
      if (ackSeen < target) checkOutput("ack within budget", 32'(ackSeen), 32'(target));
      #1;
      fetchReq = 0;
      dmemReq = 0;
      rdyStuck = 0;
      rdyFrom = 0;
   endtask

   // One access on the main instance; disturb drops req and scrambles port inputs after grant
   task automatic applyStimulus(input bit isFetch, input bit we, input logic [7:0] addr,
                                input logic [7:0] wdata, input int rdyLow, input bit stuck,
                                input bit disturb);
      expT x;
      int  r;
      int  target;
      @(posedge clk);
      #1;
      r = cyc;
      rdyStuck = stuck;
      if (isFetch) begin
         fetchReq = 1;
         fetchAddr = addr;
      end else begin
         dmemReq = 1;
         dmemWe = we;
         dmemAddr = addr;
         dmemWdata = wdata;
      end
      x.isFetch = isFetch;
      x.err = stuck;
      x.addr = addr;
      x.wdata = wdata;
      if (we) begin
         rdyFrom = r + 2 + rdyLow;
         x.ackCyc = stuck ? r + 17 : r + 3 + rdyLow;
         x.weCycles = stuck ? 15 : rdyLow + 1;
      end else begin
         rdyFrom = r + 3 + rdyLow;
         x.ackCyc = stuck ? r + 18 : r + 4 + rdyLow;
         x.weCycles = 0;
         if (isFetch) trkFetch = stuck ? 8'hFF : tbMem[addr];
         else         trkDmem  = stuck ? 8'hFF : tbMem[addr];
      end
      x.fdata = trkFetch;
      x.ddata = trkDmem;
      expQ.push_back(x);
      target = ackSeen + 1;
      if (disturb) begin
         @(posedge clk);
         #1;
         fetchReq = 0;
         dmemReq = 0;
         fetchAddr = ~addr;
         dmemAddr = ~addr;
         dmemWdata = ~wdata;
         dmemWe = ~we;
      end
      waitAcks(target, 40);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r;
      int target;
      int aleCyc;
      int ackCyc;
      int released;
      int drivenOut;
      logic [7:0] dataB;
      expT x;

      for (int i = 0; i < 256; i++) tbMem[i] = 8'(i * 7 + 3) ^ 8'h5A;
      tbMem[8'h10] = 8'hA5;

      repeat (2) @(negedge clk);
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset rw_mem", 32'(rwMem), 0);
      checkOutput("reset mem_out", 32'(memOut), 0);
      checkOutput("reset mem_ale", 32'(memAle), 0);
      checkOutput("reset mem_we", 32'(memWe), 0);
      checkOutput("reset fetch_ack", 32'(fetchAck), 0);
      checkOutput("reset dmem_ack", 32'(dmemAck), 0);
      checkOutput("reset err", 32'(err), 0);
      checkOutput("reset fetch_data", 32'(fetchData), 0);
      checkOutput("reset dmem_rdata", 32'(dmemRdata), 0);
      @(posedge clk);
      #1;
      rst = 0;

      applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 0);
      applyStimulus(0, 0, 8'h33, 8'h00, 0, 0, 0);
      applyStimulus(0, 1, 8'h20, 8'h3C, 3, 0, 1);
      applyStimulus(0, 1, 8'h21, 8'hC3, 0, 0, 0);
      applyStimulus(0, 0, 8'h34, 8'h00, 2, 0, 1);
      applyStimulus(1, 0, 8'h77, 8'h00, 1, 0, 0);

      // Both ports held: data wins twice, then fetch is forced in
      @(posedge clk);
      #1;
      r = cyc;
      fetchReq = 1;
      fetchAddr = 8'h40;
      dmemReq = 1;
      dmemWe = 0;
      dmemAddr = 8'h50;
      for (int k = 0; k < 6; k++) begin
         x.isFetch = (k % 3 == 2);
         x.err = 0;
         x.addr = x.isFetch ? 8'h40 : 8'h50;
         x.wdata = 0;
         x.weCycles = 0;
         x.ackCyc = r + 4 + 5 * k;
         if (x.isFetch) trkFetch = tbMem[8'h40];
         else           trkDmem  = tbMem[8'h50];
         x.fdata = trkFetch;
         x.ddata = trkDmem;
         expQ.push_back(x);
      end
      waitAcks(ackSeen + 6, 60);

      applyStimulus(0, 0, 8'h60, 8'h00, 0, 1, 0);
      applyStimulus(0, 1, 8'h61, 8'h5E, 0, 1, 0);

      // Reset in the middle of a write data phase
      @(posedge clk);
      #1;
      dmemReq = 1;
      dmemWe = 1;
      dmemAddr = 8'h70;
      dmemWdata = 8'h99;
      rdyStuck = 1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("in write phase before reset", 32'(memWe), 1);
      rst = 1;
      #1;
      checkOutput("reset mid rw_mem", 32'(rwMem), 0);
      checkOutput("reset mid mem_we", 32'(memWe), 0);
      checkOutput("reset mid busy", 32'(busy), 0);
      checkOutput("reset mid fetch_data", 32'(fetchData), 0);
      checkOutput("reset mid dmem_rdata", 32'(dmemRdata), 0);
      dmemReq = 0;
      rdyStuck = 0;
      rdyFrom = 0;
      trkFetch = 0;
      trkDmem = 0;
      @(posedge clk);
      #1;
      rst = 0;

      applyStimulus(0, 1, 8'h71, 8'h42, 0, 0, 0);
      applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 0);

      // Three-cycle turnaround instance
      @(posedge clk);
      #1;
      r = cyc;
      fetchReqB = 1;
      fetchAddrB = 8'h10;
      aleCyc = -1;
      ackCyc = -1;
      released = 0;
      drivenOut = 0;
      dataB = 0;
      for (int i = 0; i < 20 && ackCyc < 0; i++) begin
         @(negedge clk);
         if (memAleB) aleCyc = cyc;
         if (aleCyc >= 0 && cyc > aleCyc && !fetchAckB) begin
            if (!rwMemB) released++;
            if (memOutB != 0) drivenOut++;
         end
         if (fetchAckB) begin
            ackCyc = cyc;
            dataB = fetchDataB;
         end
      end
      @(posedge clk);
      #1;
      fetchReqB = 0;
      checkOutput("turn3 ale cycle", 32'(aleCyc), 32'(r + 1));
      checkOutput("turn3 ack cycle", 32'(ackCyc), 32'(r + 6));
      checkOutput("turn3 released cycles", 32'(released), 4);
      checkOutput("turn3 mem_out idle", 32'(drivenOut), 0);
      checkOutput("turn3 fetch_data", 32'(dataB), 32'h A5);

      repeat (3) @(posedge clk);
      checkOutput("scoreboard drained", 32'(expQ.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
